// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package mux_pkg;

    // Channel selection modes.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Largest supported channel count; the priority search works on this width.
    localparam int MAX_CH = 16;

    // Priority search over an already-rotated request vector.
    // Returns {found, index of the lowest set bit}.
    function automatic logic [4:0] lowest_set(input logic [MAX_CH-1:0] v);
        logic       found;
        logic [3:0] idx;
        found = 1'b0;
        idx   = 4'd0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                found = 1'b1;
                idx   = 4'(i);
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: rotates the request vector so that ptr is the
// highest priority position, picks the lowest set bit, then maps the pick
// back to an absolute channel number. Output grant is one-hot or zero.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] grant
);

    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W:0]    rot_idx;
    logic [4:0]        pick;
    logic [SEL_W:0]    abs_idx;

    // Rotate: rot[i] is the request of channel (ptr + i) mod NUM_CH.
    always_comb begin
        rot     = '0;
        rot_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rot_idx = {1'b0, ptr} + (SEL_W + 1)'(i);
            if (rot_idx >= NUM_CH_W) begin
                rot_idx = rot_idx - NUM_CH_W;
            end
            rot[i] = req[rot_idx[SEL_W-1:0]];
        end
    end

    // Priority-encode the rotated vector, unrotate, and expand to one-hot.
    always_comb begin
        pick    = lowest_set(MAX_CH'(rot));
        abs_idx = {1'b0, ptr} + (SEL_W + 1)'(pick[3:0]);
        if (abs_idx >= NUM_CH_W) begin
            abs_idx = abs_idx - NUM_CH_W;
        end
        grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            grant[i] = en && pick[4] && (abs_idx[SEL_W-1:0] == SEL_W'(i));
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel stream multiplexer with a single registered output stage.
// Handshake: a word moves on any interface in a cycle where both valid and
// ready are high at the rising edge; valid never waits on ready, while
// in_ready is a combinational function of in_valid, mode, sel, rr_ptr and
// out_ready.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    // Derived from NUM_CH; leave at its default.
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [NUM_CH-1:0] rr_grant;
    logic [NUM_CH-1:0] fixed_grant;
    logic [NUM_CH-1:0] grant;
    logic              sel_ok;
    logic              load_ok;
    logic              xfer;
    logic [SEL_W-1:0]  xfer_ch;
    logic [SEL_W-1:0]  xfer_next;
    logic [DATA_W-1:0] xfer_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .en    (mode == MODE_RR),
        .grant (rr_grant)
    );

    // FIXED-mode grant; sel values with no matching channel grant nothing.
    always_comb begin
        sel_ok      = 1'b0;
        fixed_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ok         = 1'b1;
                fixed_grant[i] = in_valid[i];
            end
        end
    end

    // Mode gating, ready generation and selection of the winning word.
    always_comb begin
        grant     = (mode == MODE_RR) ? rr_grant : fixed_grant;
        load_ok   = !out_valid_q || out_ready;
        in_ready  = rst ? '0 : (grant & {NUM_CH{load_ok}});
        xfer      = |(in_ready & in_valid);
        xfer_ch   = '0;
        xfer_next = '0;
        xfer_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ready[i]) begin
                xfer_ch   = SEL_W'(i);
                xfer_next = (i == NUM_CH - 1) ? '0 : SEL_W'(i + 1);
                xfer_data = in_data[i*DATA_W +: DATA_W];
            end
        end
        sel_err = !rst && (mode == MODE_FIXED) && !sel_ok && (|in_valid);
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = xfer_data;
            out_ch_d    = xfer_ch;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = xfer_next;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: a 4-channel instance for the main behaviour and a
// 3-channel instance for the out-of-range select case.
module tb_stream_mux_n;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;
    localparam int N3 = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic          mode;
    logic [SW-1:0] sel;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_ch;
    logic          out_valid;
    logic          out_ready;
    logic          sel_err;

    logic [N3*W-1:0] in_data3;
    logic [N3-1:0]   in_valid3;
    logic [N3-1:0]   in_ready3;
    logic            mode3;
    logic [1:0]      sel3;
    logic [W-1:0]    out_data3;
    logic [1:0]      out_ch3;
    logic            out_valid3;
    logic            out_ready3;
    logic            sel_err3;

    int checks = 0;
    int errors = 0;

    // Reference state for the 4-channel instance.
    int             m_valid;
    int             m_data;
    int             m_ch;
    int             m_ptr;

    always #5 clk = ~clk;

    stream_mux_n #(.NUM_CH(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    stream_mux_n #(.NUM_CH(N3), .DATA_W(W)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3),
        .sel_err(sel_err3)
    );

    // Which channel the rules say should win right now, or -1.
    function automatic int exp_grant();
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (rst || g < 0 || !(m_valid == 0 || out_ready)) return '0;
        return N'(1) << g;
    endfunction

    // Advance the reference by one clock edge using the inputs seen at it.
    task automatic model_commit();
        int g;
        if (rst) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
            return;
        end
        g = exp_grant();
        if (g >= 0 && (m_valid == 0 || out_ready)) begin
            m_data  = int'(in_data[g*W +: W]);
            m_ch    = g;
            m_valid = 1;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    // One clock: wait for the edge, update the reference, settle past the edge.
    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '1; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tick(); tick();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
        checks++; if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", dut.rr_ptr_q); end
        checks++; if (out_data !== 8'h00 || out_ch !== 2'd0) begin errors++; $display("FAIL reset_out_regs got %h/%0d want 00/0", out_data, out_ch); end
        checks++; if (sel_err3 !== 1'b0 || in_ready3 !== 3'b000) begin errors++; $display("FAIL reset_dut3 got err %0b rdy %b want 0 000", sel_err3, in_ready3); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin errors++; $display("FAIL reset_first_word got v%0b ch%0d %h want v1 ch0 11", out_valid, out_ch, out_data); end
        in_valid = '0;
        tick();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b1111;
        in_data = {8'(($urandom)), 8'hA5, 8'(($urandom)), 8'(($urandom))};
        #3;
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
        tick();
        in_valid = '0;
        #3;
        checks++; if (out_data !== 8'hA5 || out_ch !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL fixed_word got %h ch%0d v%0b want a5 ch2 v1", out_data, out_ch, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fixed_drain got v%0b want 0", out_valid); end
    endtask

    task automatic test_rr_all();
        int seq[5] = '{0, 1, 2, 3, 0};
        rst = 1'b1; in_valid = '0; tick();
        rst = 1'b0;
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_data = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
            tick();
            checks++; if (out_ch !== SW'(seq[i]) || out_valid !== 1'b1) begin errors++; $display("FAIL rr_all step%0d got ch%0d v%0b want ch%0d v1", i, out_ch, out_valid, seq[i]); end
            checks++; if (out_data !== 8'((seq[i] + 1) * 16 + i)) begin errors++; $display("FAIL rr_all_data step%0d got %h want %h", i, out_data, 8'((seq[i] + 1) * 16 + i)); end
        end
    endtask

    task automatic test_rr_sparse();
        int seq[4] = '{1, 3, 1, 3};
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_ch !== SW'(seq[i]) || out_valid !== 1'b1) begin errors++; $display("FAIL rr_sparse step%0d got ch%0d v%0b want ch%0d v1", i, out_ch, out_valid, seq[i]); end
        end
    endtask

    task automatic test_backpressure();
        in_valid = '0; out_ready = 1'b1; tick();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = {24'h0, 8'h3C};
        out_ready = 1'b0;
        tick();
        in_data = {24'h0, 8'h77};
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready cycle%0d got %b want 0000", i, in_ready); end
            checks++; if (out_data !== 8'h3C || out_valid !== 1'b1 || out_ch !== 2'd0) begin errors++; $display("FAIL bp_hold cycle%0d got %h v%0b want 3c v1", i, out_data, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #3;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got %b want 0001", in_ready); end
        tick();
        in_valid = '0;
        checks++; if (out_data !== 8'h77 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got %h v%0b want 77 v1", out_data, out_valid); end
        tick();
    endtask

    task automatic test_sel_err();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if (sel_err3 !== 1'b1 || in_ready3 !== 3'b000 || out_valid3 !== 1'b0) begin errors++; $display("FAIL sel_err cycle%0d got err%0b rdy%b v%0b want 1 000 0", i, sel_err3, in_ready3, out_valid3); end
            tick();
        end
        in_valid3 = 3'b000;
        #3;
        checks++; if (sel_err3 !== 1'b0) begin errors++; $display("FAIL sel_err_idle got %0b want 0", sel_err3); end
        in_valid3 = 3'b111; sel3 = 2'd1;
        #1;
        checks++; if (sel_err3 !== 1'b0 || in_ready3 !== 3'b010) begin errors++; $display("FAIL sel_ok got err%0b rdy%b want 0 010", sel_err3, in_ready3); end
        tick();
        checks++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd1 || out_data3 !== 8'hB1) begin errors++; $display("FAIL sel_ok_word got v%0b ch%0d %h want v1 ch1 b1", out_valid3, out_ch3, out_data3); end
        mode3 = 1'b1; sel3 = 2'd3;
        #1;
        checks++; if (sel_err3 !== 1'b0) begin errors++; $display("FAIL sel_err_rr got %0b want 0", sel_err3); end
        in_valid3 = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] er;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom_range(0, (1 << N) - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = (N*W)'({$urandom, $urandom});
            #3;
            er = exp_ready();
            checks++; if (in_ready !== er) begin errors++; $display("FAIL rand_ready c%0d got %b want %b", c, in_ready, er); end
            checks++; if (out_valid !== 1'(m_valid)) begin errors++; $display("FAIL rand_valid c%0d got %0b want %0d", c, out_valid, m_valid); end
            if (m_valid != 0) begin
                checks++; if (out_data !== W'(m_data) || out_ch !== SW'(m_ch)) begin errors++; $display("FAIL rand_word c%0d got %h ch%0d want %h ch%0d", c, out_data, out_ch, m_data, m_ch); end
            end
            checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rand_sel_err c%0d got %0b want 0", c, sel_err); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;
        #1;
        test_reset();
        test_fixed();
        test_rr_all();
        test_rr_sparse();
        test_backpressure();
        test_sel_err();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
